// File: rtl/ending_scan_ctrl.sv
// ending_scan_ctrl: VGA scan generator for the ending screen.
// Produces the line and frame counters and a 3-stage pixel pipeline, which
// gives window coordinates to the image fetch stage and takes its pixels back.
// A request FSM makes sure a new ending selection only takes effect at frame start.
// Optional build macro: ENDING_FADE_EN adds a per-frame fade-in of window pixels.
module ending_scan_ctrl #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          WIN_X0   = 152,
    parameter int          WIN_Y0   = 191,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        end_req,
    input  logic        end_kind,
    output logic        end_ack,
    output logic [8:0]  x_pos,
    output logic [6:0]  y_pos,
    output logic        ending_type,
    input  logic [23:0] pixel_in,
    output logic [23:0] vga_rgb,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int WIN_W   = 336;
    localparam int WIN_H   = 98;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] WX_BEGIN  = HW'(WIN_X0);
    localparam logic [HW-1:0] WX_END    = HW'(WIN_X0 + WIN_W - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] WY_BEGIN  = VW'(WIN_Y0);
    localparam logic [VW-1:0] WY_END    = VW'(WIN_Y0 + WIN_H - 1);

    typedef enum logic {
        IDLE,
        PENDING
    } req_state_t;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          frame_start;

    logic          in_win_c;
    logic          active_c;
    logic          hsync_c;
    logic          vsync_c;
    logic [8:0]    x_next;
    logic [6:0]    y_next;

    logic          win_s1, act_s1, hsy_s1, vsy_s1;
    logic          win_s2, act_s2, hsy_s2, vsy_s2;
    logic [23:0]   win_pixel;

    req_state_t    state, state_next;
    logic          kind_q, kind_next;
    logic          take;
    logic          type_next;

    // Free-running line/frame counters; reset parks them at frame start.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign frame_start = (h_cnt == '0) && (v_cnt == '0);

    // Decode window, active area and sync regions from the raw counters.
    always_comb begin
        in_win_c = (h_cnt >= WX_BEGIN) && (h_cnt <= WX_END) &&
                   (v_cnt >= WY_BEGIN) && (v_cnt <= WY_END);
        active_c = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hsync_c  = (h_cnt >= HS_BEGIN) && (h_cnt <= HS_END);
        vsync_c  = (v_cnt >= VS_BEGIN) && (v_cnt <= VS_END);
        x_next   = 9'(h_cnt - WX_BEGIN);
        y_next   = 7'(v_cnt - WY_BEGIN);
    end

    // Stage 1: window-relative coordinates go out to the fetch stage.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            x_pos  <= '0;
            y_pos  <= '0;
            win_s1 <= 1'b0;
            act_s1 <= 1'b0;
            hsy_s1 <= 1'b0;
            vsy_s1 <= 1'b0;
        end else begin
            x_pos  <= in_win_c ? x_next : '0;
            y_pos  <= in_win_c ? y_next : '0;
            win_s1 <= in_win_c;
            act_s1 <= active_c;
            hsy_s1 <= hsync_c;
            vsy_s1 <= vsync_c;
        end
    end

    // Stage 2: flags wait while the fetch stage looks up the pixel.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            win_s2 <= 1'b0;
            act_s2 <= 1'b0;
            hsy_s2 <= 1'b0;
            vsy_s2 <= 1'b0;
        end else begin
            win_s2 <= win_s1;
            act_s2 <= act_s1;
            hsy_s2 <= hsy_s1;
            vsy_s2 <= vsy_s1;
        end
    end

`ifdef ENDING_FADE_EN
    logic [5:0] fade;

    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [5:0] f);
        logic [6:0] mult;
        mult = {1'b0, f} + 7'd1;
        return 8'(({6'd0, c} * {7'd0, mult}) >> 6);
    endfunction

    // Fade level restarts with each new ending and climbs once per frame.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            fade <= '0;
        end else if (take) begin
            fade <= '0;
        end else if (frame_start && (fade != 6'd63)) begin
            fade <= fade + 6'd1;
        end
    end

    // Scale each colour channel of the fetched pixel by the fade level.
    always_comb begin
        win_pixel = {scale_chan(pixel_in[23:16], fade),
                     scale_chan(pixel_in[15:8],  fade),
                     scale_chan(pixel_in[7:0],   fade)};
    end
`else
    assign win_pixel = pixel_in;
`endif

    // Stage 3: final colour mux and active-low syncs, registered to the pins.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vga_rgb     <= 24'h0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            vga_rgb     <= act_s2 ? (win_s2 ? win_pixel : BG_COLOR) : 24'h0;
            vga_hs      <= ~hsy_s2;
            vga_vs      <= ~vsy_s2;
            vga_blank_n <= act_s2;
        end
    end

    // Request FSM state, latched kind and the frame-stable ending outputs.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state       <= IDLE;
            kind_q      <= 1'b0;
            end_ack     <= 1'b0;
            ending_type <= 1'b0;
        end else begin
            state       <= state_next;
            kind_q      <= kind_next;
            end_ack     <= take;
            ending_type <= type_next;
        end
    end

    // Latch requests and apply them only at frame start; a request arriving
    // exactly at frame start wins over any older pending one.
    always_comb begin
        state_next = state;
        kind_next  = kind_q;
        take       = 1'b0;
        type_next  = ending_type;
        if (frame_start) begin
            if (end_req) begin
                take       = 1'b1;
                type_next  = end_kind;
                state_next = IDLE;
            end else if (state == PENDING) begin
                take       = 1'b1;
                type_next  = kind_q;
                state_next = IDLE;
            end
        end else if (end_req) begin
            state_next = PENDING;
            kind_next  = end_kind;
        end
    end

endmodule
